// File: rtl/periph_obi_arbiter_pkg.sv
// Shared types and constants for the peripheral OBI arbiter.
package periph_obi_arbiter_pkg;

  localparam int PERIPH_ARB_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/periph_obi_arbiter_if.sv
// Bus bundle between the hart-side crossbar outputs, the arbiter and periph_system.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface periph_obi_arbiter_if
  import periph_obi_arbiter_pkg::*;
#(
  parameter int NHARTS = 3
);

  obi_req_t  [NHARTS-1:0] master_req_i;
  obi_resp_t [NHARTS-1:0] master_resp_o;
  obi_req_t               slave_req_o;
  obi_resp_t              slave_resp_i;
  logic                   protocol_err_o;

  modport slave (
    input  master_req_i,
    input  slave_resp_i,
    output master_resp_o,
    output slave_req_o,
    output protocol_err_o
  );

  modport master (
    output master_req_i,
    output slave_resp_i,
    input  master_resp_o,
    input  slave_req_o,
    input  protocol_err_o
  );

endinterface

// File: rtl/periph_arb_id_fifo.sv
// Owner-index FIFO: remembers which hart owns each granted-but-unanswered transaction.
module periph_arb_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/periph_obi_arbiter.sv
// Round-robin OBI arbiter sharing the periph_system slave port among the harts.
// Request and response paths are purely combinational; only arbitration state is registered.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ARB_IDLE   | free round-robin selection each cycle
// ARB_LOCKED | request presented without gnt; selection pinned to lock_idx
module periph_obi_arbiter
  import periph_obi_arbiter_pkg::*;
#(
  parameter int NHARTS          = 3,
  parameter int MAX_OUTSTANDING = PERIPH_ARB_MAX_OUTSTANDING
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  periph_obi_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NHARTS);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       sel_idx;
  logic [IDX_W-1:0]       head_idx;
  logic                   sel_req;
  logic                   handshake;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  obi_req_t               slave_req;
  obi_resp_t [NHARTS-1:0] master_resp;
  logic                   protocol_err;

  // Round-robin search: first requesting index at or after rr_ptr, with wrap-around.
  always_comb begin
    int  cand;
    logic found;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NHARTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NHARTS) cand = cand - NHARTS;
      if (!found && bus.master_req_i[cand].req) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

  // Selection, request mux, issue gating and lock FSM next-state.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    slave_req  = '0;

    sel_idx = (state_q == ARB_LOCKED) ? lock_idx_q : winner;
    // Outputs are held quiet while reset is asserted.
    sel_req = rst_ni && bus.master_req_i[sel_idx].req;

    if (sel_req) begin
      slave_req.addr  = bus.master_req_i[sel_idx].addr;
      slave_req.we    = bus.master_req_i[sel_idx].we;
      slave_req.be    = bus.master_req_i[sel_idx].be;
      slave_req.wdata = bus.master_req_i[sel_idx].wdata;
    end
    slave_req.req = sel_req && !fifo_full;
    handshake     = slave_req.req && bus.slave_resp_i.gnt;

    case (state_q)
      ARB_IDLE: begin
        if (slave_req.req && !bus.slave_resp_i.gnt) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = winner;
        end
      end
      ARB_LOCKED: begin
        // A dropped req is illegal OBI; abandon the lock rather than hang.
        if (!sel_req || handshake) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (handshake) begin
      rr_ptr_d = (sel_idx == IDX_W'(NHARTS - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Grant routing and response demux by FIFO head; rdata goes to everyone.
  always_comb begin
    master_resp  = '0;
    pop          = rst_ni && bus.slave_resp_i.rvalid && !fifo_empty;
    protocol_err = rst_ni && bus.slave_resp_i.rvalid && fifo_empty;
    for (int i = 0; i < NHARTS; i++) begin
      master_resp[i].rdata  = bus.slave_resp_i.rdata;
      master_resp[i].gnt    = handshake && (sel_idx == IDX_W'(i));
      master_resp[i].rvalid = pop && (head_idx == IDX_W'(i));
    end
  end

  periph_arb_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .pop    (pop),
    .wdata  (sel_idx),
    .rdata  (head_idx),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.slave_req_o    = slave_req;
  assign bus.master_resp_o  = master_resp;
  assign bus.protocol_err_o = protocol_err;

endmodule

// File: tb/tb_periph_obi_arbiter.sv
// Directed bench for periph_obi_arbiter: reset, fairness, lock, full FIFO,
// spurious response, simultaneous push/pop and reset mid-operation.
module tb_periph_obi_arbiter;
  import periph_obi_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  periph_obi_arbiter_if #(.NHARTS(3)) bus ();

  periph_obi_arbiter #(
    .NHARTS          (3),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [2:0] gnt_vec;
  logic [2:0] rv_vec;
  assign gnt_vec = {bus.master_resp_o[2].gnt, bus.master_resp_o[1].gnt, bus.master_resp_o[0].gnt};
  assign rv_vec  = {bus.master_resp_o[2].rvalid, bus.master_resp_o[1].rvalid, bus.master_resp_o[0].rvalid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input logic r, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
    bus.master_req_i[h].req   = r;
    bus.master_req_i[h].addr  = a;
    bus.master_req_i[h].we    = w;
    bus.master_req_i[h].be    = 4'hF;
    bus.master_req_i[h].wdata = d;
  endtask

  task automatic slave(input logic g, input logic rv, input logic [31:0] rd);
    bus.slave_resp_i.gnt    = g;
    bus.slave_resp_i.rvalid = rv;
    bus.slave_resp_i.rdata  = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    drive(1, 1'b1, 32'h0000_0104, 1'b0, 32'h0);
    drive(2, 1'b1, 32'h0000_0108, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'hFFFF_FFFF);

    // Reset held with everyone requesting and stray rvalid present.
    #2;
    chk("rst_gnt", {29'd0, gnt_vec}, 32'h0);
    chk("rst_sreq", {31'd0, bus.slave_req_o.req}, 32'h0);
    chk("rst_saddr", bus.slave_req_o.addr, 32'h0);
    chk("rst_rvalid", {29'd0, rv_vec}, 32'h0);
    chk("rst_perr", {31'd0, bus.protocol_err_o}, 32'h0);
    cyc();
    chk("rst_gnt_clk", {29'd0, gnt_vec}, 32'h0);
    rst_n = 1'b1;
    slave(1'b1, 1'b0, 32'h0);

    // Fairness: grants 0,1,2,0,1,2; each rvalid one cycle after its grant.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) slave(1'b1, 1'b1, 32'hD000_0100 + 32'(4 * ((k - 1) % 3)));
      else       slave(1'b1, 1'b0, 32'h0);
      settle();
      chk("fair_gnt", {29'd0, gnt_vec}, 32'(1 << (k % 3)));
      chk("fair_addr", bus.slave_req_o.addr, 32'h0000_0100 + 32'(4 * (k % 3)));
      if (k > 0) begin
        chk("fair_rvalid", {29'd0, rv_vec}, 32'(1 << ((k - 1) % 3)));
        chk("fair_rdata", bus.master_resp_o[(k - 1) % 3].rdata,
            32'hD000_0100 + 32'(4 * ((k - 1) % 3)));
      end
      cyc();
    end
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(2, 1'b0, 32'h0, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'hD000_0108);
    settle();
    chk("fair_last_rv", {29'd0, rv_vec}, 32'h4);
    chk("idle_sreq", {31'd0, bus.slave_req_o.req}, 32'h0);
    chk("idle_saddr", bus.slave_req_o.addr, 32'h0);
    cyc();

    // Lock: hart 2 held without gnt for 3 cycles; hart 0 joins in cycle 1.
    drive(2, 1'b1, 32'h0000_0040, 1'b1, 32'hCAFE_0040);
    slave(1'b0, 1'b0, 32'h0);
    settle();
    chk("lock0_addr", bus.slave_req_o.addr, 32'h40);
    chk("lock0_we", {31'd0, bus.slave_req_o.we}, 32'h1);
    chk("lock0_wdata", bus.slave_req_o.wdata, 32'hCAFE_0040);
    chk("lock0_gnt", {29'd0, gnt_vec}, 32'h0);
    cyc();
    drive(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    settle();
    chk("lock1_addr", bus.slave_req_o.addr, 32'h40);
    chk("lock1_gnt", {29'd0, gnt_vec}, 32'h0);
    cyc();
    settle();
    chk("lock2_addr", bus.slave_req_o.addr, 32'h40);
    chk("lock2_gnt0", {31'd0, bus.master_resp_o[0].gnt}, 32'h0);
    cyc();
    slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("lock3_gnt", {29'd0, gnt_vec}, 32'h4);
    chk("lock3_addr", bus.slave_req_o.addr, 32'h40);
    cyc();
    drive(2, 1'b0, 32'h0, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'h5555_0040);
    settle();
    chk("lock4_gnt", {29'd0, gnt_vec}, 32'h1);
    chk("lock4_addr", bus.slave_req_o.addr, 32'h100);
    chk("lock4_rv", {29'd0, rv_vec}, 32'h4);
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'h6666_0100);
    settle();
    chk("lock5_rv", {29'd0, rv_vec}, 32'h1);
    chk("lock5_perr", {31'd0, bus.protocol_err_o}, 32'h0);
    cyc();

    // Full FIFO: single requester, rvalid 4 cycles after grant.
    drive(1, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("full0_gnt", {29'd0, gnt_vec}, 32'h2);
    cyc();
    settle();
    chk("full1_gnt", {29'd0, gnt_vec}, 32'h2);
    cyc();
    settle();
    chk("full2_sreq", {31'd0, bus.slave_req_o.req}, 32'h0);
    chk("full2_gnt", {29'd0, gnt_vec}, 32'h0);
    cyc();
    settle();
    chk("full3_sreq", {31'd0, bus.slave_req_o.req}, 32'h0);
    cyc();
    slave(1'b1, 1'b1, 32'hAAAA_0001);
    settle();
    chk("full4_sreq", {31'd0, bus.slave_req_o.req}, 32'h0);
    chk("full4_rv", {29'd0, rv_vec}, 32'h2);
    cyc();
    slave(1'b1, 1'b1, 32'hAAAA_0002);
    settle();
    chk("full5_gnt", {29'd0, gnt_vec}, 32'h2);
    chk("full5_rv", {29'd0, rv_vec}, 32'h2);
    cyc();
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'hAAAA_0003);
    settle();
    chk("full6_rv", {29'd0, rv_vec}, 32'h2);
    chk("full6_perr", {31'd0, bus.protocol_err_o}, 32'h0);
    cyc();

    // Spurious response with an empty FIFO.
    slave(1'b1, 1'b1, 32'hBAD0_0000);
    settle();
    chk("spur_perr", {31'd0, bus.protocol_err_o}, 32'h1);
    chk("spur_rv", {29'd0, rv_vec}, 32'h0);
    cyc();
    slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("spur_perr_clr", {31'd0, bus.protocol_err_o}, 32'h0);
    cyc();

    // Simultaneous push/pop at occupancy 1, responses ordered hart 1 then 2.
    drive(1, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("sim0_gnt", {29'd0, gnt_vec}, 32'h2);
    cyc();
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(2, 1'b1, 32'h0000_0304, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'h1111_1111);
    settle();
    chk("sim1_gnt", {29'd0, gnt_vec}, 32'h4);
    chk("sim1_rv", {29'd0, rv_vec}, 32'h2);
    chk("sim1_rdata", bus.master_resp_o[1].rdata, 32'h1111_1111);
    cyc();
    drive(2, 1'b0, 32'h0, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'h2222_2222);
    settle();
    chk("sim2_rv", {29'd0, rv_vec}, 32'h4);
    chk("sim2_perr", {31'd0, bus.protocol_err_o}, 32'h0);
    cyc();
    settle();
    chk("sim3_perr", {31'd0, bus.protocol_err_o}, 32'h1);
    chk("sim3_rv", {29'd0, rv_vec}, 32'h0);
    cyc();

    // Reset mid-operation clears the outstanding owner.
    drive(0, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("mid_gnt", {29'd0, gnt_vec}, 32'h1);
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    slave(1'b1, 1'b1, 32'h3333_3333);
    settle();
    chk("mid_perr", {31'd0, bus.protocol_err_o}, 32'h1);
    chk("mid_rv", {29'd0, rv_vec}, 32'h0);
    cyc();
    slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("mid_perr_clr", {31'd0, bus.protocol_err_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
